// File: rtl/aes_pkg.sv
// Shared AES constants and helpers for the inverse round-key generator.
// Contents: key-size mode enum, Nk/Nr lookups, Rcon table, forward S-box,
// SubWord and InvMixColumns.
package aes_pkg;

  typedef enum logic [1:0] {
    AES128 = 2'b00,
    AES192 = 2'b01,
    AES256 = 2'b10
  } aes_mode_e;

  function automatic logic [3:0] mode_nk(input logic [1:0] m);
    case (m)
      AES128:  return 4'd4;
      AES192:  return 4'd6;
      default: return 4'd8;
    endcase
  endfunction

  function automatic logic [3:0] mode_nr(input logic [1:0] m);
    return mode_nk(m) + 4'd6;
  endfunction

  localparam logic [10:1][7:0] RCON = {8'h36, 8'h1b, 8'h80, 8'h40, 8'h20,
                                       8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

  function automatic logic [7:0] rcon(input logic [3:0] q);
    if (q >= 4'd1 && q <= 4'd10) return RCON[q];
    return 8'h00;
  endfunction

  localparam logic [0:255][7:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TBL[x];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Column transform with the inverse matrix rows {0e 0b 0d 09} rotated.
  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [3:0][7:0] a, m9, mb, md, me;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) begin
        logic [7:0] x2, x4, x8;
        a[j]  = s[127 - 32*c - 8*j -: 8];
        x2    = xtime(a[j]);
        x4    = xtime(x2);
        x8    = xtime(x4);
        m9[j] = x8 ^ a[j];
        mb[j] = x8 ^ x2 ^ a[j];
        md[j] = x8 ^ x4 ^ a[j];
        me[j] = x8 ^ x4 ^ x2;
      end
      o[127 - 32*c -: 32] = {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                             m9[0] ^ me[1] ^ mb[2] ^ md[3],
                             md[0] ^ m9[1] ^ me[2] ^ mb[3],
                             mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_key_word_fn.sv
// Key-schedule word function g(x, i) shared by forward expansion and
// backward stepping.
//   word_i : previous word x      idx_i : schedule index i
//   nk_i   : key length in words  word_o: g(x, i)
module aes_key_word_fn
  import aes_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [5:0]  idx_i,
  input  logic [3:0]  nk_i,
  output logic [31:0] word_o
);
  logic [5:0] rem;
  logic [3:0] quot;

  // i mod Nk and i / Nk; Nk=6 is the only case needing a real divide.
  always_comb begin
    rem  = '0;
    quot = '0;
    case (nk_i)
      4'd4: begin
        rem  = {4'd0, idx_i[1:0]};
        quot = idx_i[5:2];
      end
      4'd6: begin
        rem  = idx_i % 6'd6;
        quot = 4'(idx_i / 6'd6);
      end
      default: begin
        rem  = {3'd0, idx_i[2:0]};
        quot = {1'b0, idx_i[5:3]};
      end
    endcase
  end

  always_comb begin
    word_o = word_i;
    if (rem == 6'd0)
      word_o = sub_word({word_i[23:0], word_i[31:24]}) ^ {rcon(quot), 24'h0};
    else if (nk_i == 4'd8 && rem == 6'd4)
      word_o = sub_word(word_i);
  end

endmodule

// File: rtl/aes_inv_roundkey_gen.sv
// Inverse AES key-schedule engine: expands the cipher key forward to the
// last round key, then walks the schedule backward emitting round keys
// Nr..0 on a valid/ready stream. Only an Nk-word sliding window is held.
//   clk, rst_n         : clock, async active-low reset
//   start, mode, key_in: request (sampled in IDLE only; mode 11 ignored)
//   busy, done         : activity flag, one-cycle completion pulse
//   rk_valid/rk_ready  : round-key handshake; rk_data, rk_round, rk_last
// Optional: define AES_INVKEY_MIXCOL_EN to emit InvMixColumns-transformed
// keys for rounds 1..Nr-1 (equivalent inverse cipher).
module aes_inv_roundkey_gen
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   mode,
  input  logic [255:0] key_in,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_round,
  output logic         rk_last,
  output logic         done
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_EXPAND = 3'd1;
  localparam logic [2:0] S_OFFER  = 3'd2;
  localparam logic [2:0] S_STEP   = 3'd3;
  localparam logic [2:0] S_FIN    = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [7:0][31:0] win_q, win_d;   // win_q[0] holds w[b]
  logic [5:0]       b_q, b_d;
  logic [3:0]       r_q, r_d, nk_q, nk_d;
  logic             gap_q, gap_d;   // forces a bubble after each handshake

  logic [2:0]   nk_m1;
  logic         is_step;
  logic [31:0]  g_x, g_y, exp_word, step_word;
  logic [5:0]   g_idx, b_last, r_base, r_next_base;
  logic [255:0] key_al;

  assign nk_m1   = 3'(nk_q - 4'd1);
  assign is_step = (state_q == S_STEP);

  // Forward: g(w[b+Nk-1], b+Nk).  Backward: g(w[b+Nk-2], b+Nk-1).
  assign g_x   = is_step ? win_q[3'(nk_m1 - 3'd1)] : win_q[nk_m1];
  assign g_idx = is_step ? 6'(b_q + 6'(nk_q) - 6'd1) : 6'(b_q + 6'(nk_q));

  aes_key_word_fn u_g (
    .word_i (g_x),
    .idx_i  (g_idx),
    .nk_i   (nk_q),
    .word_o (g_y)
  );

  assign exp_word    = win_q[0] ^ g_y;
  assign step_word   = win_q[nk_m1] ^ g_y;
  assign b_last      = 6'({nk_q, 1'b0}) + 6'(nk_q) + 6'd28;  // 4(Nr+1)-Nk
  assign r_base      = {r_q, 2'b00};
  assign r_next_base = {r_q - 4'd1, 2'b00};
  // Left-justify the Nk-word key so w0 lands in the top word.
  assign key_al      = key_in << ((8 - int'(mode_nk(mode))) * 32);

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    b_d     = b_q;
    r_d     = r_q;
    nk_d    = nk_q;
    gap_d   = gap_q;
    case (state_q)
      S_IDLE: begin
        if (start && mode != 2'b11) begin
          for (int j = 0; j < 8; j++) win_d[j] = key_al[255 - 32*j -: 32];
          nk_d    = mode_nk(mode);
          b_d     = '0;
          r_d     = '0;
          gap_d   = 1'b0;
          state_d = S_EXPAND;
        end
      end
      S_EXPAND: begin
        for (int j = 0; j < 8; j++) begin
          if (3'(j) == nk_m1)     win_d[j] = exp_word;
          else if (3'(j) < nk_m1) win_d[j] = win_q[3'(j + 1)];
        end
        b_d = b_q + 6'd1;
        if (b_d == b_last) begin
          r_d     = nk_q + 4'd6;
          state_d = S_OFFER;
        end
      end
      S_OFFER: begin
        if (gap_q) gap_d = 1'b0;
        else if (rk_ready) begin
          if (r_q == 4'd0) state_d = S_FIN;
          else begin
            r_d   = r_q - 4'd1;
            gap_d = 1'b1;
            if (r_next_base < b_q) state_d = S_STEP;
          end
        end
      end
      S_STEP: begin
        win_d = {win_q[6:0], step_word};
        b_d   = b_q - 6'd1;
        if (b_d == r_base) state_d = S_OFFER;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      win_q   <= '0;
      b_q     <= '0;
      r_q     <= '0;
      nk_q    <= '0;
      gap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      b_q     <= b_d;
      r_q     <= r_d;
      nk_q    <= nk_d;
      gap_q   <= gap_d;
    end
  end

  logic [2:0]   off;
  logic [127:0] raw_key, key_out;

  assign off     = 3'(r_base - b_q);
  assign raw_key = {win_q[off], win_q[3'(off + 3'd1)],
                    win_q[3'(off + 3'd2)], win_q[3'(off + 3'd3)]};

`ifdef AES_INVKEY_MIXCOL_EN
  assign key_out = (r_q != 4'd0 && r_q != nk_q + 4'd6) ? inv_mix_columns(raw_key)
                                                        : raw_key;
`else
  assign key_out = raw_key;
`endif

  assign rk_valid = (state_q == S_OFFER) && !gap_q;
  assign rk_data  = rk_valid ? key_out : '0;
  assign rk_round = r_q;
  assign rk_last  = rk_valid && (r_q == 4'd0);
  assign done     = (state_q == S_FIN);
  assign busy     = (state_q == S_EXPAND) || (state_q == S_OFFER) ||
                    (state_q == S_STEP);

endmodule

// File: tb/tb_aes_inv_roundkey_gen.sv
module tb_aes_inv_roundkey_gen;
  logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0, rk_ready = 1'b1;
  logic [1:0]   mode = 2'b00;
  logic [255:0] key_in = '0;
  logic         busy, rk_valid, rk_last, done;
  logic [127:0] rk_data;
  logic [3:0]   rk_round;

  always #5 clk = ~clk;

  aes_inv_roundkey_gen dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .key_in(key_in),
    .busy(busy), .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_data(rk_data),
    .rk_round(rk_round), .rk_last(rk_last), .done(done)
  );

  typedef struct {logic [3:0] r; logic [127:0] d; logic last;} exp_t;
  exp_t         sb[$];
  int           n_cmp = 0, n_bad = 0, n_hs = 0;
  logic [7:0]   sbx[256];
  logic [31:0]  wm[60];
  logic [127:0] got[16];
  bit           exp_done = 0, bp_en = 0, held = 0;
  logic [127:0] hd;
  logic [3:0]   hr;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // ---------------- reference model (GF(2^8) arithmetic) ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 0; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p ^= aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] v, p;
      v = 8'(x); p = 8'h01;
      if (x != 0) for (int k = 0; k < 254; k++) p = gmul(p, v);
      else p = 8'h00;
      sbx[x] = p ^ rotl8(p, 1) ^ rotl8(p, 2) ^ rotl8(p, 3) ^ rotl8(p, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sbx[x[31:24]], sbx[x[23:16]], sbx[x[15:8]], sbx[x[7:0]]};
  endfunction

`ifdef AES_INVKEY_MIXCOL_EN
  function automatic logic [127:0] inv_mc(input logic [127:0] s);
    logic [7:0] k[4];
    logic [127:0] o;
    k[0] = 8'h0e; k[1] = 8'h0b; k[2] = 8'h0d; k[3] = 8'h09;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++) begin
        logic [7:0] v;
        v = 0;
        for (int j = 0; j < 4; j++) v ^= gmul(s[127 - 32*c - 8*j -: 8], k[(j - row + 4) % 4]);
        o[127 - 32*c - 8*row -: 8] = v;
      end
    return o;
  endfunction
`endif

  // Full forward expansion, then queue every round key in descending order.
  task automatic model_push(input logic [1:0] m, input logic [255:0] k);
    int nk, nr;
    logic [7:0] rc;
    logic [31:0] t;
    nk = (m == 2'b00) ? 4 : (m == 2'b01) ? 6 : 8;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) wm[i] = k[(nk - 1 - i)*32 +: 32];
    for (int i = nk; i < 4*(nr + 1); i++) begin
      t = wm[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk == 8 && i % 8 == 4) t = subw(t);
      wm[i] = wm[i-nk] ^ t;
    end
    for (int r = nr; r >= 0; r--) begin
      exp_t e;
      e.r = 4'(r);
      e.d = {wm[4*r], wm[4*r+1], wm[4*r+2], wm[4*r+3]};
`ifdef AES_INVKEY_MIXCOL_EN
      if (r != 0 && r != nr) e.d = inv_mc(e.d);
`endif
      e.last = (r == 0);
      sb.push_back(e);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin held = 0; exp_done = 0; continue; end
    if (held) begin
      chk("hold_valid", rk_valid, 1'b1);
      chk("hold_data", rk_data, hd);
      chk("hold_round", rk_round, hr);
      held = 0;
    end
    if (done || exp_done) begin
      chk("done_pulse", done, exp_done);
      exp_done = 0;
    end
    if (rk_valid && rk_ready) begin
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL extra_key: round %0d unexpected", rk_round);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rk_round", rk_round, e.r);
        chk("rk_data", rk_data, e.d);
        chk("rk_last", rk_last, e.last);
        got[rk_round] = rk_data;
        n_hs++;
        if (e.last) exp_done = 1;
      end
    end else if (rk_valid) begin
      held = 1; hd = rk_data; hr = rk_round;
    end
  end

  initial forever begin
    @(posedge clk); #1;
    rk_ready = bp_en ? ($urandom_range(0, 2) != 0) : 1'b1;
  end

  // ---------------- stimulus ----------------
  function automatic logic [255:0] rnd_key();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic run_key(input logic [1:0] m, input logic [255:0] k, input int lat, input bit poke);
    int cyc, n;
    for (int i = 0; i < 16; i++) got[i] = '0;
    n_hs = 0;
    model_push(m, k);
    @(posedge clk); #1;
    mode = m; key_in = k; start = 1;
    @(posedge clk); #1;
    start = 0; cyc = 1;
    chk("busy_after_start", busy, 1'b1);
    if (poke) begin
      start = 1; mode = 2'b10; key_in = rnd_key();
      @(posedge clk); #1;
      start = 0; cyc++;
    end
    while (!rk_valid && cyc < 300) begin @(posedge clk); #1; cyc++; end
    chk("first_valid_lat", cyc, lat);
    if (poke) begin
      start = 1; mode = 2'b00; key_in = rnd_key();
      @(posedge clk); #1;
      start = 0;
    end
    n = 0;
    while (!done && n < 3000) begin @(posedge clk); #1; n++; end
    chk("done_seen", done, 1'b1);
    chk("sb_empty", sb.size(), 0);
    @(posedge clk); #1;
    chk("idle_after_done", {busy, done}, 2'b00);
  endtask

  task automatic do_reset();
    rst_n = 0; #1;
    chk("async_reset_outs", {busy, rk_valid, rk_data, rk_round, rk_last, done}, '0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  initial begin
    int n;
    build_sbox();
    repeat (2) @(posedge clk); #1;
    chk("reset_state", {busy, rk_valid, rk_data, rk_round, rk_last, done}, '0);
    rst_n = 1;

    run_key(2'b00, 256'h000102030405060708090a0b0c0d0e0f, 41, 0);
    chk("aes128_r10", got[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    chk("aes128_r0", got[0], 128'h000102030405060708090a0b0c0d0e0f);

    run_key(2'b00, 256'h2b7e151628aed2a6abf7158809cf4f3c, 41, 0);
    chk("fips128_r10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    run_key(2'b01, 256'h000102030405060708090a0b0c0d0e0f1011121314151617, 47, 0);
    chk("aes192_r12", got[12], 128'ha4970a331a78dc09c418c271e3a41d5d);
    chk("aes192_nkeys", n_hs, 13);

    run_key(2'b10, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 53, 0);
    chk("aes256_r14", got[14], 128'h24fc79ccbf0979e9371ac23c6d68de36);
`ifndef AES_INVKEY_MIXCOL_EN
    chk("aes256_r1", got[1], 128'h101112131415161718191a1b1c1d1e1f);
`endif
    chk("aes256_r0", got[0], 128'h000102030405060708090a0b0c0d0e0f);

    // reserved mode must not start anything
    @(posedge clk); #1;
    mode = 2'b11; key_in = rnd_key(); start = 1;
    @(posedge clk); #1;
    start = 0;
    chk("mode11_busy", busy, 1'b0);
    repeat (3) @(posedge clk); #1;
    chk("mode11_quiet", {busy, rk_valid}, 2'b00);

    // random keys, random backpressure, start pokes while busy
    bp_en = 1;
    for (int t = 0; t < 6; t++) begin
      logic [1:0] m;
      m = 2'($urandom_range(0, 2));
      run_key(m, rnd_key(), (m == 2'b00) ? 41 : (m == 2'b01) ? 47 : 53, 1);
    end

    // abort during EXPAND, then a clean run
    model_push(2'b01, rnd_key());
    @(posedge clk); #1;
    mode = 2'b01; key_in = rnd_key(); start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (20) @(posedge clk); #1;
    do_reset();
    run_key(2'b01, rnd_key(), 47, 0);

    // abort while offering round 5, then a clean run
    model_push(2'b00, 256'h2b7e151628aed2a6abf7158809cf4f3c);
    @(posedge clk); #1;
    mode = 2'b00; key_in = 256'h2b7e151628aed2a6abf7158809cf4f3c; start = 1;
    @(posedge clk); #1;
    start = 0; n = 0;
    while (!(rk_valid && rk_round == 4'd5) && n < 2000) begin @(posedge clk); #1; n++; end
    chk("reached_r5", {rk_valid, rk_round}, {1'b1, 4'd5});
    do_reset();
    run_key(2'b00, 256'h2b7e151628aed2a6abf7158809cf4f3c, 41, 0);
    chk("post_abort_r10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    bp_en = 0;
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
